// File: rtl/alpha_mul_seq.sv
// rtl/alpha_mul_seq.sv - SNOW-3G MULalpha feedback term, one MULx stage iterated 245 cycles
// out = (s0 << 8) ^ MULalpha(s0[31:24]), constant latency regardless of the input byte.

module alpha_mul_seq #(
   parameter logic [7:0] POLY = 8'hA9
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [7:0] CAP_B3   = 8'd23;
   localparam logic [7:0] CAP_B1   = 8'd48;
   localparam logic [7:0] CAP_B0   = 8'd239;
   localparam logic [7:0] CAP_LAST = 8'd245;

   state_t      state;
   state_t      state_nxt;
   logic [7:0]  v;
   logic [7:0]  v_mulx;
   logic [7:0]  cnt;
   logic [7:0]  cnt_inc;
   logic [31:0] low;
   logic [7:0]  r_b3;
   logic [7:0]  r_b1;
   logic [7:0]  r_b0;

   function automatic logic [7:0] mulx(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? POLY : 8'h00);
   endfunction

   // Captures compare against the post-increment count so the byte taken is x^n * c.
   assign v_mulx  = mulx(v);
   assign cnt_inc = cnt + 8'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (in_valid) state_nxt = ITER;
         ITER: if (cnt_inc == CAP_LAST) state_nxt = DONE;
         DONE: if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE);
      busy      = (state == ITER);
      out_valid = (state == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v        <= 8'h00;
         cnt      <= 8'h00;
         low      <= 32'h0;
         r_b3     <= 8'h00;
         r_b1     <= 8'h00;
         r_b0     <= 8'h00;
         out_data <= 32'h0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  v   <= in_data[31:24];
                  low <= {in_data[23:0], 8'h00};
                  cnt <= 8'h00;
               end
            end
            ITER: begin
               v   <= v_mulx;
               cnt <= cnt_inc;
               if (cnt_inc == CAP_B3) r_b3 <= v_mulx;
               if (cnt_inc == CAP_B1) r_b1 <= v_mulx;
               if (cnt_inc == CAP_B0) r_b0 <= v_mulx;
               // The x^245 byte is the last one produced, so it feeds the result directly.
               if (cnt_inc == CAP_LAST) out_data <= low ^ {r_b3, v_mulx, r_b1, r_b0};
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alpha_mul_seq.sv
// tb/tb_alpha_mul_seq.sv - self-checking bench for alpha_mul_seq
// Reference computes MULalpha directly from repeated multiplication by x in GF(2^8).

module tb_alpha_mul_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        busy;

   int total = 0;
   int bad   = 0;

   logic [31:0] sweep_in  [256];
   logic [31:0] sweep_out [256];

   alpha_mul_seq dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] mulxpow(input logic [7:0] c, input int n);
      logic [7:0] p;
      p = c;
      for (int i = 0; i < n; i++) begin
         if (p[7]) p = {p[6:0], 1'b0} ^ 8'hA9;
         else      p = {p[6:0], 1'b0};
      end
      return p;
   endfunction

   function automatic logic [31:0] ref_out(input logic [31:0] s0);
      logic [7:0] c;
      c = s0[31:24];
      return {s0[23:0], 8'h00} ^
             {mulxpow(c, 23), mulxpow(c, 245), mulxpow(c, 48), mulxpow(c, 239)};
   endfunction

   // Drives one word and waits for the result; completes the transfer only if out_ready is high.
   task automatic run_word(input logic [31:0] d, output logic [31:0] res,
                           output int lat, output bit ok);
      @(negedge clk);
      in_data  = d;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 0;
      ok  = 1'b0;
      while (!ok && lat < 400) begin
         @(posedge clk);
         lat++;
         #1;
         if (out_valid) ok = 1'b1;
      end
      res = out_data;
      if (ok && out_ready) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = 32'h0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      total++; if (out_data !== 32'h0) begin bad++; $display("FAIL reset_out_data got=%h want=00000000", out_data); end
   endtask

   task automatic test_one;
      logic [31:0] res;
      int lat;
      bit ok;
      run_word(32'h01000000, res, lat, ok);
      total++; if (ok !== 1'b1) begin bad++; $display("FAIL one_timeout got=%b want=1", ok); end
      total++; if (lat !== 245) begin bad++; $display("FAIL one_latency got=%0d want=245", lat); end
      total++; if (res[31:24] !== 8'hE1) begin bad++; $display("FAIL one_top_byte got=%h want=e1", res[31:24]); end
      total++; if (res !== ref_out(32'h01000000)) begin bad++; $display("FAIL one_word got=%h want=%h", res, ref_out(32'h01000000)); end
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL one_back_idle got=%b%b want=01", out_valid, in_ready); end
   endtask

   task automatic test_zero_byte;
      logic [31:0] res;
      int lat;
      bit ok;
      run_word(32'h00ABCDEF, res, lat, ok);
      total++; if (lat !== 245) begin bad++; $display("FAIL zero_latency got=%0d want=245", lat); end
      total++; if (res !== 32'hABCDEF00) begin bad++; $display("FAIL zero_word got=%h want=abcdef00", res); end
   endtask

   task automatic test_backpressure;
      logic [31:0] res;
      logic [31:0] res2;
      int lat;
      bit ok;
      int bad_cycles;
      out_ready = 1'b0;
      run_word(32'h5A3C9F01, res, lat, ok);
      total++; if (res !== ref_out(32'h5A3C9F01)) begin bad++; $display("FAIL bp_word got=%h want=%h", res, ref_out(32'h5A3C9F01)); end
      bad_cycles = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         in_valid = i[0];
         in_data  = 32'hDEAD0000 | i;
         @(posedge clk);
         #1;
         if (out_data !== res || in_ready !== 1'b0 || out_valid !== 1'b1 || busy !== 1'b0) bad_cycles++;
      end
      total++; if (bad_cycles !== 0) begin bad++; $display("FAIL bp_hold got=%0d bad cycles want=0", bad_cycles); end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=%b%b want=01", out_valid, in_ready); end
      run_word(32'h80FFFFFF, res2, lat, ok);
      total++; if (res2 !== ref_out(32'h80FFFFFF) || lat !== 245) begin bad++; $display("FAIL bp_next got=%h lat=%0d want=%h lat=245", res2, lat, ref_out(32'h80FFFFFF)); end
   endtask

   task automatic test_reset_mid;
      logic [31:0] res;
      int lat;
      bit ok;
      int seen;
      @(negedge clk);
      in_data  = 32'hFF123456;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (100) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      total++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL midrst_state got=%b%b%b want=100", in_ready, busy, out_valid); end
      total++; if (out_data !== 32'h0) begin bad++; $display("FAIL midrst_data got=%h want=00000000", out_data); end
      @(negedge clk);
      rst  = 1'b0;
      seen = 0;
      repeat (300) begin
         @(posedge clk);
         #1;
         if (out_valid) seen++;
      end
      total++; if (seen !== 0) begin bad++; $display("FAIL midrst_no_output got=%0d want=0", seen); end
      run_word(32'hFF123456, res, lat, ok);
      total++; if (res !== ref_out(32'hFF123456) || lat !== 245) begin bad++; $display("FAIL midrst_resubmit got=%h lat=%0d want=%h lat=245", res, lat, ref_out(32'hFF123456)); end
   endtask

   task automatic test_random_sweep;
      logic [31:0] rnd;
      logic [31:0] d;
      logic [31:0] res;
      int lat;
      bit ok;
      for (int i = 0; i < 256; i++) begin
         rnd = $urandom();
         d   = {i[7:0], rnd[23:0]};
         run_word(d, res, lat, ok);
         sweep_in[i]  = d;
         sweep_out[i] = res;
         total++; if (res !== ref_out(d) || lat !== 245) begin bad++; $display("FAIL sweep[%0d] in=%h got=%h lat=%0d want=%h lat=245", i, d, res, lat, ref_out(d)); end
      end
   endtask

   task automatic test_linearity;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      int lat;
      bit ok;
      int ia;
      int ib;
      for (int k = 0; k < 32; k++) begin
         ia = $urandom_range(255, 0);
         ib = $urandom_range(255, 0);
         a  = sweep_in[ia];
         b  = sweep_in[ib];
         run_word(a ^ b, res, lat, ok);
         total++; if (res !== (sweep_out[ia] ^ sweep_out[ib])) begin bad++; $display("FAIL linear[%0d] a=%h b=%h got=%h want=%h", k, a, b, res, sweep_out[ia] ^ sweep_out[ib]); end
      end
   endtask

   initial begin
      test_reset();
      test_one();
      test_zero_byte();
      test_backpressure();
      test_reset_mid();
      test_random_sweep();
      test_linearity();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
